mul_digit_serial_accum: RTL

//  Digit-serial NxN unsigned multiplier built around one external 2x2 digit multiplier.

---
 rtl/mul_digit_pkg.sv | 19 +
 rtl/mul_digit_idx_ctr.sv | 39 +++
 rtl/mul_digit_serial_accum.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul_digit_pkg.sv
// Shared constants, state encoding and digit-shift helper
// for the digit-serial multiplier.
package mul_digit_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIGIT     = 2;
    localparam int NDIG      = WIDTH_DEF / DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_shift(input int i, input int j);
        return (i + j) * DIGIT;
    endfunction

endpackage

// File: rtl/mul_digit_idx_ctr.sv
// Nested digit-pair counter: j is the fast index, i advances
// when j wraps; last flags the final (COUNT-1, COUNT-1) pair.
module mul_digit_idx_ctr
    import mul_digit_pkg::*;
#(
    parameter int COUNT = NDIG,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic          last
);

    localparam logic [IW-1:0] MAX = IW'(COUNT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
        end else if (en) begin
            if (j == MAX) begin
                j <= '0;
                i <= (i == MAX) ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

    assign last = (i == MAX) && (j == MAX);

endmodule

// File: rtl/mul_digit_serial_accum.sv
// Digit-serial NxN unsigned multiplier driving an external 2x2
// digit cell and accumulating shifted digit products.
module mul_digit_serial_accum
    import mul_digit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [DIGIT-1:0]     mul_a,
    output logic [DIGIT-1:0]     mul_b,
    input  logic [2*DIGIT-1:0]   mul_p,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int ND = WIDTH / DIGIT;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int PW = 2 * WIDTH;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     p_r;
    logic [PW-1:0]     term;
    logic [PW-1:0]     acc_sum;
    logic [IW-1:0]     i;
    logic [IW-1:0]     j;
    logic              last;
    logic              accept;
    logic              run;

    assign accept = (state == IDLE) && start;
    assign run    = (state == RUN);

    mul_digit_idx_ctr #(
        .COUNT (ND),
        .IW    (IW)
    ) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (run),
        .i     (i),
        .j     (j),
        .last  (last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Digit selects come from the registered indices; idle drives zero.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (run) begin
            mul_a = a_r[DIGIT*i +: DIGIT];
            mul_b = b_r[DIGIT*j +: DIGIT];
        end
    end

    assign term    = PW'(mul_p) << digit_shift(int'(i), int'(j));
    assign acc_sum = acc + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            p_r   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_r <= A;
                b_r <= B;
                acc <= '0;
            end else if (run) begin
                acc <= acc_sum;
                if (last) p_r <= acc_sum;
            end
        end
    end

    assign P    = p_r;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
